// File: rtl/mod5_seq_ctrl.sv
// Two-requester divisibility-by-5 checker: round-robin arbitration, then a
// bit-serial (MSB first) remainder engine that reports rem, div5 and the requester id.
module mod5_seq_ctrl #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0,
  input  logic [W-1:0] data0,
  input  logic         req1,
  input  logic [W-1:0] data1,
  output logic [1:0]   gnt,
  output logic         busy,
  output logic         ser_bit,
  output logic         done,
  output logic [2:0]   rem,
  output logic         div5,
  output logic         id
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [W-1:0]   r_shift;
  logic [2:0]     r_work;
  logic [CW-1:0]  r_cnt;
  logic           r_sel;
  logic           r_last;
  logic [2:0]     r_rem;
  logic           r_div5;
  logic           r_id;

  logic           w_any_req;
  logic           w_pick1;
  logic           w_last_bit;
  logic [2:0]     w_rem_nxt;

  // Appending one bit to the operand: r' = (2r + b) mod 5. Out-of-range r recovers to 0.
  function automatic logic [2:0] mod5_step(input logic [2:0] r, input logic b);
    logic [2:0] res;
    case ({r, b})
      4'b000_0: res = 3'd0;
      4'b000_1: res = 3'd1;
      4'b001_0: res = 3'd2;
      4'b001_1: res = 3'd3;
      4'b010_0: res = 3'd4;
      4'b010_1: res = 3'd0;
      4'b011_0: res = 3'd1;
      4'b011_1: res = 3'd2;
      4'b100_0: res = 3'd3;
      4'b100_1: res = 3'd4;
      default:  res = 3'd0;
    endcase
    return res;
  endfunction

  assign w_any_req  = req0 | req1;
  // Requester 1 wins alone, or under contention when requester 0 was served last.
  assign w_pick1    = req1 & (~req0 | ~r_last);
  assign w_last_bit = (r_cnt == CW'(W - 1));
  assign w_rem_nxt  = mod5_step(r_work, r_shift[W-1]);

  always_comb begin
    gnt         = 2'b00;
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (rst_n && w_any_req) begin
          gnt         = w_pick1 ? 2'b10 : 2'b01;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (w_last_bit) begin
          w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_work  <= 3'd0;
      r_cnt   <= '0;
      r_sel   <= 1'b0;
      r_last  <= 1'b1;
      r_rem   <= 3'd0;
      r_div5  <= 1'b0;
      r_id    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_shift <= w_pick1 ? data1 : data0;
            r_work  <= 3'd0;
            r_cnt   <= '0;
            r_sel   <= w_pick1;
            r_last  <= w_pick1;
          end
        end
        SHIFT: begin
          r_work  <= w_rem_nxt;
          r_shift <= {r_shift[W-2:0], 1'b0};
          r_cnt   <= r_cnt + CW'(1);
          // Result registers take the final remainder as the last bit is consumed.
          if (w_last_bit) begin
            r_rem  <= w_rem_nxt;
            r_div5 <= (w_rem_nxt == 3'd0);
            r_id   <= r_sel;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy    = (r_state != IDLE);
  assign done    = (r_state == DONE);
  assign ser_bit = (r_state == SHIFT) & r_shift[W-1];
  assign rem     = r_rem;
  assign div5    = r_div5;
  assign id      = r_id;

endmodule

// File: tb/tb_mod5_seq_ctrl.sv
// Directed bench for mod5_seq_ctrl (W=8): reset, single jobs, round robin,
// busy-time request blocking and reset abort.
module tb_mod5_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1;
  logic [7:0] data0, data1;
  logic [1:0] gnt;
  logic       busy, ser_bit, done, div5, id;
  logic [2:0] rem;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mod5_seq_ctrl #(.W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .data0(data0), .req1(req1), .data1(data1),
    .gnt(gnt), .busy(busy), .ser_bit(ser_bit), .done(done),
    .rem(rem), .div5(div5), .id(id)
  );

  // Issues one request, then observes grant, serial bits, latency and result.
  task automatic run_job(input logic which, input logic [7:0] d,
                         output logic [1:0] g, output logic [7:0] bits, output int lat,
                         output logic [2:0] o_rem, output logic o_div5, output logic o_id);
    o_rem = 3'bxxx; o_div5 = 1'bx; o_id = 1'bx; lat = -1; bits = 8'h00;
    @(negedge clk);
    if (which) begin req1 = 1'b1; data1 = d; end
    else begin req0 = 1'b1; data0 = d; end
    #1 g = gnt;
    @(negedge clk);
    req0 = 1'b0; req1 = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      #1;
      if (done) begin
        lat = k; o_rem = rem; o_div5 = div5; o_id = id;
        break;
      end
      bits = {bits[6:0], ser_bit};
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req0 = 1'b1; req1 = 1'b1; data0 = 8'd5; data1 = 8'd6;
    repeat (3) @(negedge clk);
    #1;
    total++; if (gnt !== 2'b00) begin bad++; $display("FAIL reset_gnt: got %b want 00", gnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (ser_bit !== 1'b0) begin bad++; $display("FAIL reset_ser: got %b want 0", ser_bit); end
    total++; if ({rem, div5, id} !== 5'b0) begin bad++; $display("FAIL reset_result: got rem=%0d div5=%b id=%b want 0/0/0", rem, div5, id); end
    @(negedge clk);
    req0 = 1'b0; req1 = 1'b0; rst_n = 1'b1;
    #1;
    total++; if (gnt !== 2'b00) begin bad++; $display("FAIL idle_gnt: got %b want 00", gnt); end
  endtask

  task automatic test_single_req0;
    logic [1:0] g; logic [7:0] bits; int lat; logic [2:0] r; logic dv, i;
    run_job(1'b0, 8'd25, g, bits, lat, r, dv, i);
    total++; if (g !== 2'b01) begin bad++; $display("FAIL r0_gnt: got %b want 01", g); end
    total++; if (bits !== 8'b0001_1001) begin bad++; $display("FAIL r0_bits: got %b want 00011001", bits); end
    total++; if (lat != 9) begin bad++; $display("FAIL r0_latency: got %0d want 9", lat); end
    total++; if ({r, dv, i} !== {3'd0, 1'b1, 1'b0}) begin bad++; $display("FAIL r0_result: got rem=%0d div5=%b id=%b want 0/1/0", r, dv, i); end
  endtask

  task automatic test_req1_seq;
    logic [1:0] g; logic [7:0] bits; int lat; logic [2:0] r; logic dv, i;
    run_job(1'b1, 8'd7, g, bits, lat, r, dv, i);
    total++; if (g !== 2'b10) begin bad++; $display("FAIL r1_7_gnt: got %b want 10", g); end
    total++; if ({r, dv, i} !== {3'd2, 1'b0, 1'b1}) begin bad++; $display("FAIL r1_7_result: got rem=%0d div5=%b id=%b want 2/0/1", r, dv, i); end
    run_job(1'b1, 8'd255, g, bits, lat, r, dv, i);
    total++; if (bits !== 8'hFF) begin bad++; $display("FAIL r1_255_bits: got %b want 11111111", bits); end
    total++; if ({r, dv, i} !== {3'd0, 1'b1, 1'b1}) begin bad++; $display("FAIL r1_255_result: got rem=%0d div5=%b id=%b want 0/1/1", r, dv, i); end
    run_job(1'b1, 8'd201, g, bits, lat, r, dv, i);
    total++; if (lat != 9) begin bad++; $display("FAIL r1_201_latency: got %0d want 9", lat); end
    total++; if ({r, dv, i} !== {3'd1, 1'b0, 1'b1}) begin bad++; $display("FAIL r1_201_result: got rem=%0d div5=%b id=%b want 1/0/1", r, dv, i); end
  endtask

  // Both requesters hold requests from reset release: grants 0,1,0 ten cycles apart.
  task automatic test_back_to_back;
    int gcyc[3]; logic [1:0] gv[3]; int dcyc[3]; logic [2:0] drem[3]; logic did[3];
    int ng = 0; int nd = 0; logic drop = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1; req0 = 1'b1; req1 = 1'b1; data0 = 8'd10; data1 = 8'd3;
    for (int cyc = 0; cyc < 36; cyc++) begin
      if (drop) begin req0 = 1'b0; req1 = 1'b0; end
      #1;
      if (gnt !== 2'b00 && ng < 3) begin
        gcyc[ng] = cyc; gv[ng] = gnt; ng++;
        if (ng == 3) drop = 1'b1;
      end
      if (done === 1'b1 && nd < 3) begin
        dcyc[nd] = cyc; drem[nd] = rem; did[nd] = id; nd++;
      end
      @(negedge clk);
    end
    total++; if (ng != 3 || nd != 3) begin bad++; $display("FAIL b2b_counts: got grants=%0d dones=%0d want 3/3", ng, nd); end
    else begin
      total++; if ({gv[0], gv[1], gv[2]} !== 6'b01_10_01) begin bad++; $display("FAIL b2b_rr: got %b %b %b want 01 10 01", gv[0], gv[1], gv[2]); end
      total++; if (gcyc[1] - gcyc[0] != 10) begin bad++; $display("FAIL b2b_gap: got %0d want 10", gcyc[1] - gcyc[0]); end
      total++; if (dcyc[0] != 9) begin bad++; $display("FAIL b2b_done0_cyc: got %0d want 9", dcyc[0]); end
      total++; if ({did[0], drem[0]} !== {1'b0, 3'd0}) begin bad++; $display("FAIL b2b_done0: got id=%b rem=%0d want 0/0", did[0], drem[0]); end
      total++; if ({did[1], drem[1]} !== {1'b1, 3'd3}) begin bad++; $display("FAIL b2b_done1: got id=%b rem=%0d want 1/3", did[1], drem[1]); end
      total++; if ({did[2], drem[2], dcyc[2]} !== {1'b0, 3'd0, 32'd29}) begin bad++; $display("FAIL b2b_done2: got id=%b rem=%0d cyc=%0d want 0/0/29", did[2], drem[2], dcyc[2]); end
    end
  endtask

  // Operand 0, plus a request from requester 1 arriving mid-job.
  task automatic test_busy_ignore;
    int g1 = -1; int nd = 0; int dc[2]; logic [2:0] dr[2]; logic dd[2]; logic di[2];
    logic leak = 1'b0;
    @(negedge clk); req0 = 1'b1; data0 = 8'd0;
    #1;
    total++; if (gnt !== 2'b01) begin bad++; $display("FAIL busy_gnt0: got %b want 01", gnt); end
    @(negedge clk); req0 = 1'b0;
    for (int cyc = 1; cyc < 30; cyc++) begin
      if (cyc == 3) begin req1 = 1'b1; data1 = 8'd12; end
      if (g1 >= 0) req1 = 1'b0;
      #1;
      if (gnt !== 2'b00 && busy === 1'b1) leak = 1'b1;
      if (gnt === 2'b10 && g1 < 0) g1 = cyc;
      if (done === 1'b1 && nd < 2) begin
        dc[nd] = cyc; dr[nd] = rem; dd[nd] = div5; di[nd] = id; nd++;
      end
      @(negedge clk);
    end
    req1 = 1'b0;
    total++; if (leak !== 1'b0) begin bad++; $display("FAIL busy_leak: got grant while busy want none"); end
    total++; if (g1 != 10) begin bad++; $display("FAIL busy_regrant: got cycle %0d want 10", g1); end
    total++; if (nd != 2) begin bad++; $display("FAIL busy_dones: got %0d want 2", nd); end
    else begin
      total++; if ({dc[0], dr[0], dd[0], di[0]} !== {32'd9, 3'd0, 1'b1, 1'b0}) begin bad++; $display("FAIL zero_result: got cyc=%0d rem=%0d div5=%b id=%b want 9/0/1/0", dc[0], dr[0], dd[0], di[0]); end
      total++; if ({dr[1], dd[1], di[1]} !== {3'd2, 1'b0, 1'b1}) begin bad++; $display("FAIL busy_job2: got rem=%0d div5=%b id=%b want 2/0/1", dr[1], dd[1], di[1]); end
    end
  endtask

  task automatic test_reset_abort;
    logic [1:0] g; logic [7:0] bits; int lat; logic [2:0] r; logic dv, i;
    logic seen_done = 1'b0;
    run_job(1'b1, 8'd7, g, bits, lat, r, dv, i);
    @(negedge clk); req0 = 1'b1; data0 = 8'd25;
    @(negedge clk); req0 = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL abort_busy_pre: got %b want 1", busy); end
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    #1;
    total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL abort_ctrl: got busy=%b done=%b want 0/0", busy, done); end
    total++; if ({rem, div5, id} !== 5'b0) begin bad++; $display("FAIL abort_result: got rem=%0d div5=%b id=%b want 0/0/0", rem, div5, id); end
    for (int k = 0; k < 15; k++) begin
      @(negedge clk); #1;
      if (done === 1'b1) seen_done = 1'b1;
    end
    total++; if (seen_done !== 1'b0) begin bad++; $display("FAIL abort_done: got pulse want none"); end
    run_job(1'b0, 8'd25, g, bits, lat, r, dv, i);
    total++; if (g !== 2'b01 || lat != 9) begin bad++; $display("FAIL post_abort_job: got gnt=%b lat=%0d want 01/9", g, lat); end
    total++; if ({r, dv, i, bits} !== {3'd0, 1'b1, 1'b0, 8'd25}) begin bad++; $display("FAIL post_abort_result: got rem=%0d div5=%b id=%b bits=%b want 0/1/0/00011001", r, dv, i, bits); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; data0 = 8'd0; data1 = 8'd0;
    test_reset;
    test_single_req0;
    test_req1_seq;
    test_back_to_back;
    test_busy_ignore;
    test_reset_abort;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
